// File: rtl/s2qed_pair_gen_if.sv
// Handshake bundle for s2qed_pair_gen: source instruction channel plus the two core fetch ports.
interface s2qed_pair_gen_if;
   logic        src_valid;
   logic        src_ready;
   logic [31:0] src_inst;
   logic        cpu0_fetch_req;
   logic        cpu1_fetch_req;
   logic        cpu0_fetch_ack;
   logic        cpu1_fetch_ack;
   logic [31:0] cpu0_fetch_inst;
   logic [31:0] cpu1_fetch_inst;

   modport master (
      output src_valid, src_inst, cpu0_fetch_req, cpu1_fetch_req,
      input  src_ready, cpu0_fetch_ack, cpu1_fetch_ack, cpu0_fetch_inst, cpu1_fetch_inst
   );

   modport slave (
      input  src_valid, src_inst, cpu0_fetch_req, cpu1_fetch_req,
      output src_ready, cpu0_fetch_ack, cpu1_fetch_ack, cpu0_fetch_inst, cpu1_fetch_inst
   );
endinterface

// File: rtl/s2qed_pair_gen.sv
// Generates S2QED instruction pairs: cpu0 gets the original ALU instruction,
// cpu1 a register-renamed twin; tracks completed pairs, drops and delivery timeouts.
module s2qed_pair_gen #(
   parameter int unsigned LOCKSTEP = 1,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic            clk,
   input  logic            rst,
   s2qed_pair_gen_if.slave bus,
   output logic            illegal,
   output logic [15:0]     pair_count,
   output logic [7:0]      drop_count,
   output logic            timeout_err
);
   typedef enum logic [1:0] {IDLE, DELIVER, DONE} state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

   state_t      r_state, w_next;
   logic [31:0] r_inst0, r_inst1;
   logic        r_d0, r_d1;
   logic [7:0]  r_tcnt;
   logic        r_ack0, r_ack1;
   logic [31:0] r_out0, r_out1;
   logic        r_illegal;
   logic [15:0] r_pair_cnt;
   logic [7:0]  r_drop_cnt;
   logic        r_timeout;
   logic        w_accept, w_legal, w_grant0, w_grant1, w_tmo;

   function automatic logic [4:0] reg_map(input logic [4:0] r);
      logic [5:0] w_wide;
      w_wide = '0;
      if (r == 5'd0 || r == 5'd31) w_wide = {1'b0, r};
      else if (r <= 5'd11)         w_wide = 6'd13 - {1'b0, r};
      else if (r == 5'd12)         w_wide = 6'd13;
      else if (r == 5'd13)         w_wide = 6'd1;
      else                         w_wide = 6'd44 - {1'b0, r};
      return w_wide[4:0];
   endfunction

   function automatic logic is_legal(input logic [31:0] x);
      logic [6:0] f7;
      logic [2:0] f3;
      logic       ok;
      f7 = x[31:25];
      f3 = x[14:12];
      ok = 1'b0;
      if (x[6:0] == OPC_OP)
         ok = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      else if (x[6:0] == OPC_OP_IMM) begin
         case (f3)
            3'b001:  ok = (f7 == 7'b0000000);
            3'b101:  ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            default: ok = 1'b1;
         endcase
      end
      return ok;
   endfunction

   // OP_IMM keeps imm[11:0] (bits 31:20) untouched; only OP renames rs2.
   function automatic logic [31:0] map_inst(input logic [31:0] x);
      logic [31:0] y;
      y        = x;
      y[11:7]  = reg_map(x[11:7]);
      y[19:15] = reg_map(x[19:15]);
      if (x[6:0] == OPC_OP) y[24:20] = reg_map(x[24:20]);
      return y;
   endfunction

   assign w_legal       = is_legal(bus.src_inst);
   assign w_accept      = bus.src_valid && (r_state == IDLE);
   assign bus.src_ready = (r_state == IDLE) && !rst;

   always_comb begin
      w_next   = r_state;
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      w_tmo    = 1'b0;
      case (r_state)
         IDLE: if (w_accept && w_legal) w_next = DELIVER;
         DELIVER: begin
            if (LOCKSTEP != 0) begin
               w_grant0 = bus.cpu0_fetch_req && bus.cpu1_fetch_req && !r_d0 && !r_d1;
               w_grant1 = w_grant0;
            end else begin
               w_grant0 = bus.cpu0_fetch_req && !r_d0;
               w_grant1 = bus.cpu1_fetch_req && !r_d1;
               // A delivery landing on the final count still wins over the timeout.
               w_tmo    = (r_d0 != r_d1) && (r_tcnt == TCNT_LAST) && !w_grant0 && !w_grant1;
            end
            if (r_d0 && r_d1) w_next = DONE;
            else if (w_tmo)   w_next = IDLE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_inst0    <= '0;
         r_inst1    <= '0;
         r_d0       <= 1'b0;
         r_d1       <= 1'b0;
         r_tcnt     <= '0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_out0     <= '0;
         r_out1     <= '0;
         r_illegal  <= 1'b0;
         r_pair_cnt <= '0;
         r_drop_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_illegal <= w_accept && !w_legal;
         if (w_accept && !w_legal && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
         if (w_accept && w_legal) begin
            r_inst0 <= bus.src_inst;
            r_inst1 <= map_inst(bus.src_inst);
            r_d0    <= 1'b0;
            r_d1    <= 1'b0;
            r_tcnt  <= '0;
         end
         if (w_grant0) r_d0 <= 1'b1;
         if (w_grant1) r_d1 <= 1'b1;
         if (r_state == DELIVER && r_d0 != r_d1) r_tcnt <= r_tcnt + 8'd1;
         r_ack0 <= w_grant0;
         r_ack1 <= w_grant1;
         r_out0 <= w_grant0 ? r_inst0 : '0;
         r_out1 <= w_grant1 ? r_inst1 : '0;
         if (r_state == DONE) r_pair_cnt <= r_pair_cnt + 16'd1;
         if (w_tmo) r_timeout <= 1'b1;
      end
   end

   assign bus.cpu0_fetch_ack  = r_ack0;
   assign bus.cpu1_fetch_ack  = r_ack1;
   assign bus.cpu0_fetch_inst = r_out0;
   assign bus.cpu1_fetch_inst = r_out1;
   assign illegal             = r_illegal;
   assign pair_count          = r_pair_cnt;
   assign drop_count          = r_drop_cnt;
   assign timeout_err         = r_timeout;
endmodule

// File: tb/tb_s2qed_pair_gen.sv
// Scoreboard bench: instance A runs lockstep (TIMEOUT 64), instance B independent acks (TIMEOUT 4).
module tb_s2qed_pair_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic        ill_a, ill_b, terr_a, terr_b;
   logic [15:0] pc_a, pc_b;
   logic [7:0]  dc_a, dc_b;

   s2qed_pair_gen_if if_a ();
   s2qed_pair_gen_if if_b ();

   s2qed_pair_gen #(.LOCKSTEP(1), .TIMEOUT(64)) u_dut_a (
      .clk(clk), .rst(rst_a), .bus(if_a), .illegal(ill_a),
      .pair_count(pc_a), .drop_count(dc_a), .timeout_err(terr_a)
   );
   s2qed_pair_gen #(.LOCKSTEP(0), .TIMEOUT(4)) u_dut_b (
      .clk(clk), .rst(rst_b), .bus(if_b), .illegal(ill_b),
      .pair_count(pc_b), .drop_count(dc_b), .timeout_err(terr_b)
   );

   int n_cmp = 0;
   int n_err = 0;
   int exp_pc [2] = '{0, 0};
   int exp_dc [2] = '{0, 0};
   logic [31:0] qa0[$], qa1[$], qb0[$], qb1[$];

   int map_tab [32] = '{0, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 13, 1, 30, 29,
                        28, 27, 26, 25, 24, 23, 22, 21, 20, 19, 18, 17, 16, 15, 14, 31};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic bit m_legal(input logic [31:0] x);
      logic [6:0] f7;
      logic [2:0] f3;
      f7 = x[31:25];
      f3 = x[14:12];
      if (x[6:0] == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      if (x[6:0] == 7'h13) begin
         if (f3 == 3'd1) return f7 == 7'h00;
         if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
         return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_map(input logic [31:0] x);
      logic [31:0] y;
      y        = x;
      y[11:7]  = 5'(map_tab[x[11:7]]);
      y[19:15] = 5'(map_tab[x[19:15]]);
      if (x[6:0] == 7'h33) y[24:20] = 5'(map_tab[x[24:20]]);
      return y;
   endfunction

   // Scoreboard consumers: every ack pops one expectation, idle ports must read zero.
   always @(negedge clk) begin
      if (if_a.cpu0_fetch_ack) begin
         check("a_ack0_expected", 32'(qa0.size() != 0), 1);
         if (qa0.size() != 0) check("a_cpu0_inst", if_a.cpu0_fetch_inst, qa0.pop_front());
      end else check("a_cpu0_inst_idle", if_a.cpu0_fetch_inst, 0);
      if (if_a.cpu1_fetch_ack) begin
         check("a_ack1_expected", 32'(qa1.size() != 0), 1);
         if (qa1.size() != 0) check("a_cpu1_inst", if_a.cpu1_fetch_inst, qa1.pop_front());
      end else check("a_cpu1_inst_idle", if_a.cpu1_fetch_inst, 0);
      if (if_a.cpu0_fetch_ack || if_a.cpu1_fetch_ack)
         check("a_lockstep_acks", 32'(if_a.cpu0_fetch_ack), 32'(if_a.cpu1_fetch_ack));
   end

   always @(negedge clk) begin
      if (if_b.cpu0_fetch_ack) begin
         check("b_ack0_expected", 32'(qb0.size() != 0), 1);
         if (qb0.size() != 0) check("b_cpu0_inst", if_b.cpu0_fetch_inst, qb0.pop_front());
      end else check("b_cpu0_inst_idle", if_b.cpu0_fetch_inst, 0);
      if (if_b.cpu1_fetch_ack) begin
         check("b_ack1_expected", 32'(qb1.size() != 0), 1);
         if (qb1.size() != 0) check("b_cpu1_inst", if_b.cpu1_fetch_inst, qb1.pop_front());
      end else check("b_cpu1_inst_idle", if_b.cpu1_fetch_inst, 0);
   end

   task automatic send(input bit sel, input logic [31:0] inst, input logic [31:0] exp1);
      int unsigned n;
      bit          lg;
      string       p;
      p  = sel ? "b_" : "a_";
      lg = m_legal(inst);
      n  = 0;
      while (!(sel ? if_b.src_ready : if_a.src_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({p, "src_ready_wait"}, 32'(sel ? if_b.src_ready : if_a.src_ready), 1);
      if (sel) begin if_b.src_valid = 1'b1; if_b.src_inst = inst; end
      else     begin if_a.src_valid = 1'b1; if_a.src_inst = inst; end
      if (lg) begin
         if (sel) begin qb0.push_back(inst); qb1.push_back(exp1); end
         else     begin qa0.push_back(inst); qa1.push_back(exp1); end
      end
      @(negedge clk);
      if (sel) if_b.src_valid = 1'b0; else if_a.src_valid = 1'b0;
      check({p, "illegal_pulse"}, 32'(sel ? ill_b : ill_a), 32'(!lg));
      if (!lg && exp_dc[sel] < 255) exp_dc[sel]++;
      check({p, "drop_count"}, 32'(sel ? dc_b : dc_a), exp_dc[sel]);
      check({p, "src_ready_after_send"}, 32'(sel ? if_b.src_ready : if_a.src_ready), 32'(!lg));
   endtask

   task automatic fetch(input bit sel, input bit r0, input bit r1, output bit got0, output bit got1);
      int unsigned n;
      got0 = 1'b0;
      got1 = 1'b0;
      if (sel) begin if_b.cpu0_fetch_req = r0; if_b.cpu1_fetch_req = r1; end
      else     begin if_a.cpu0_fetch_req = r0; if_a.cpu1_fetch_req = r1; end
      n = 0;
      while (((r0 && !got0) || (r1 && !got1)) && n < 40) begin
         @(negedge clk);
         n++;
         if (sel ? if_b.cpu0_fetch_ack : if_a.cpu0_fetch_ack) begin
            got0 = 1'b1;
            if (sel) if_b.cpu0_fetch_req = 1'b0; else if_a.cpu0_fetch_req = 1'b0;
         end
         if (sel ? if_b.cpu1_fetch_ack : if_a.cpu1_fetch_ack) begin
            got1 = 1'b1;
            if (sel) if_b.cpu1_fetch_req = 1'b0; else if_a.cpu1_fetch_req = 1'b0;
         end
      end
   endtask

   // Called on the negedge of the final ack: one DONE cycle, then IDLE with the count bumped.
   task automatic finish_pair(input bit sel);
      string p;
      p = sel ? "b_" : "a_";
      @(negedge clk);
      check({p, "ready_in_done"}, 32'(sel ? if_b.src_ready : if_a.src_ready), 0);
      @(negedge clk);
      exp_pc[sel] = (exp_pc[sel] + 1) % 65536;
      check({p, "pair_count"}, 32'(sel ? pc_b : pc_a), exp_pc[sel]);
      check({p, "ready_after_pair"}, 32'(sel ? if_b.src_ready : if_a.src_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit          g0, g1;
      logic [31:0] x;

      rst_a = 1'b1; rst_b = 1'b1;
      if_a.src_valid = 1'b0; if_a.src_inst = '0; if_a.cpu0_fetch_req = 1'b0; if_a.cpu1_fetch_req = 1'b0;
      if_b.src_valid = 1'b0; if_b.src_inst = '0; if_b.cpu0_fetch_req = 1'b0; if_b.cpu1_fetch_req = 1'b0;
      repeat (3) @(negedge clk);
      check("a_rst_src_ready", 32'(if_a.src_ready), 0);
      check("a_rst_acks", {30'd0, if_a.cpu1_fetch_ack, if_a.cpu0_fetch_ack}, 0);
      check("a_rst_counts", {pc_a, dc_a, 6'd0, ill_a, terr_a}, 0);
      check("b_rst_counts", {pc_b, dc_b, 6'd0, ill_b, terr_b}, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("a_ready_after_rst", 32'(if_a.src_ready), 1);

      // Lockstep: ADD and ADDI reference vectors
      send(0, 32'h003100B3, 32'h00A58633);
      fetch(0, 1, 1, g0, g1);
      check("a_add_acks", {30'd0, g1, g0}, 3);
      finish_pair(0);
      send(0, 32'h005F8713, 32'h005F8F13);
      fetch(0, 1, 1, g0, g1);
      check("a_addi_acks", {30'd0, g1, g0}, 3);
      finish_pair(0);

      // Mixed OP / OP_IMM encodings, legal and illegal
      for (int i = 0; i < 12; i++) begin
         x = $urandom;
         x[6:0] = (i % 2 == 0) ? 7'b0110011 : 7'b0010011;
         if (i % 4 == 0) x[31:25] = 7'h00;
         else if (i % 4 == 1) x[31:25] = 7'h20;
         send(0, x, m_map(x));
         if (m_legal(x)) begin
            fetch(0, 1, 1, g0, g1);
            check("a_rand_acks", {30'd0, g1, g0}, 3);
            finish_pair(0);
         end
      end

      // LW is dropped; drop_count saturates
      for (int i = 0; i < 257; i++) send(0, 32'h00002003, 32'h0);
      check("a_drop_saturated", 32'(dc_a), 32'hFF);
      @(negedge clk);
      check("a_illegal_one_cycle", 32'(ill_a), 0);

      // Lockstep hold-off: cpu0 alone never gets acked
      send(0, 32'h40F75833, m_map(32'h40F75833));
      if_a.cpu0_fetch_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("a_no_solo_ack", {30'd0, if_a.cpu1_fetch_ack, if_a.cpu0_fetch_ack}, 0);
      end
      fetch(0, 1, 1, g0, g1);
      check("a_late_pair_acks", {30'd0, g1, g0}, 3);
      finish_pair(0);
      check("a_no_timeout", 32'(terr_a), 0);

      // Independent acks, staggered then simultaneous
      send(1, 32'h00002003, 32'h0);
      send(1, 32'h41D2D093, m_map(32'h41D2D093));
      fetch(1, 1, 0, g0, g1);
      check("b_ack0_first", {30'd0, g1, g0}, 1);
      @(negedge clk);
      fetch(1, 0, 1, g0, g1);
      check("b_ack1_later", {30'd0, g1, g0}, 2);
      finish_pair(1);
      send(1, 32'h01FF8FB3, m_map(32'h01FF8FB3));
      fetch(1, 1, 1, g0, g1);
      check("b_same_cycle_acks", {30'd0, g1, g0}, 3);
      check("b_same_cycle_seen", {30'd0, if_b.cpu1_fetch_ack, if_b.cpu0_fetch_ack}, 3);
      finish_pair(1);

      // Timeout: cpu1 never asks
      send(1, 32'h005F8713, 32'h005F8F13);
      fetch(1, 1, 0, g0, g1);
      check("b_tmo_ack0", 32'(g0), 1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("b_timeout_err", 32'(terr_b), 32'(k == 4));
      end
      check("b_idle_after_tmo", 32'(if_b.src_ready), 1);
      check("b_pair_unchanged", 32'(pc_b), exp_pc[1]);
      qb1.delete();

      send(1, 32'h003100B3, 32'h00A58633);
      fetch(1, 1, 1, g0, g1);
      finish_pair(1);
      check("b_timeout_sticky", 32'(terr_b), 1);

      // Reset mid-pair after a cpu0-only delivery
      send(1, 32'h00C68733, m_map(32'h00C68733));
      fetch(1, 1, 0, g0, g1);
      check("b_rst_ack0", 32'(g0), 1);
      qb1.delete();
      if_b.cpu1_fetch_req = 1'b1;
      rst_b = 1'b1;
      exp_pc[1] = 0;
      exp_dc[1] = 0;
      repeat (2) begin
         @(negedge clk);
         check("b_rst_no_ack1", 32'(if_b.cpu1_fetch_ack), 0);
         check("b_rst_ready_low", 32'(if_b.src_ready), 0);
         check("b_rst_counts", {pc_b, dc_b, 6'd0, ill_b, terr_b}, 0);
      end
      rst_b = 1'b0;
      @(negedge clk);
      check("b_ready_after_rst", 32'(if_b.src_ready), 1);
      check("b_post_rst_no_ack1", 32'(if_b.cpu1_fetch_ack), 0);
      if_b.cpu1_fetch_req = 1'b0;
      repeat (2) @(negedge clk);

      check("a_q0_drained", qa0.size(), 0);
      check("a_q1_drained", qa1.size(), 0);
      check("b_q0_drained", qb0.size(), 0);
      check("b_q1_drained", qb1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
